// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU constants, FSM state encodings and op codes
package alu_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } alu_op_t;

endpackage

// File: rtl/RCA_8bit.sv
// RCA_8bit: 8-bit ripple-carry adder with carry-out and signed overflow
module RCA_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       overflow
);

    logic [8:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout     = c[8];
    assign overflow = c[8] ^ c[7];

endmodule

// File: rtl/byte_serial_adder.sv
// byte_serial_adder: WIDTH-bit add/subtract computed one byte per cycle through a single 8-bit adder
module byte_serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_overflow,
    output logic             busy
);

    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int IDX_W  = NBYTES > 1 ? $clog2(NBYTES) : 1;

    state_t            state, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic [BYTE_W-1:0] byte_a, byte_b, byte_s;
    logic              add_cout, add_ovf;
    logic              last;

    // B is stored pre-inverted for subtract, so the byte pass is always a plain add
    assign byte_a    = a_reg[idx*BYTE_W +: BYTE_W];
    assign byte_b    = b_reg[idx*BYTE_W +: BYTE_W];
    assign last      = idx == IDX_W'(NBYTES - 1);
    assign in_ready  = rst_n && state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    RCA_8bit u_rca (
        .a        (byte_a),
        .b        (byte_b),
        .cin      (carry),
        .s        (byte_s),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    // State register
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_next;
    end

    // Next-state: accept in IDLE, one pass per byte in RUN, hold in DONE until consumed
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = in_valid ? RUN : IDLE;
            RUN:     state_next = last ? DONE : RUN;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-byte sum write-back and carry chaining
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            idx          <= '0;
            carry        <= 1'b0;
            out_sum      <= '0;
            out_cout     <= 1'b0;
            out_overflow <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b ^ {WIDTH{in_sub}};
            carry <= in_sub;
            idx   <= '0;
        end else if (state == RUN) begin
            out_sum[idx*BYTE_W +: BYTE_W] <= byte_s;
            carry                         <= add_cout;
            idx                           <= last ? idx : idx + 1'b1;
            out_cout                      <= last ? add_cout : out_cout;
            out_overflow                  <= last ? add_ovf : out_overflow;
        end
    end

endmodule
